// File: rtl/fas_serial_alu_if.sv
// Handshake/bus bundle for the bit-serial adder/subtractor fas_serial_alu.
// Optional feature macro: FAS_SERIAL_OVF_EN adds the signed-overflow flag ovf.
interface fas_serial_alu_if #(
    parameter int N = 8
);
    logic         start;
    logic         a_ns;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
`ifdef FAS_SERIAL_OVF_EN
    logic         ovf;
`endif

    // Requester side: issues operands and start, observes status/result
    modport master (
        output start, a_ns, a, b,
        input  busy, done, result, cout
`ifdef FAS_SERIAL_OVF_EN
        , input ovf
`endif
    );

    // ALU side: consumes operands, drives status/result
    modport slave (
        input  start, a_ns, a, b,
        output busy, done, result, cout
`ifdef FAS_SERIAL_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/fas_serial_alu.sv
// Bit-serial N-bit adder/subtractor: one full adder/subtractor cell plus a
// carry flop, one bit per clock, LSB first. Operands are latched on an
// accepted start; result/cout are registered when the last bit is processed.
// Optional feature macro: FAS_SERIAL_OVF_EN (signed overflow output ovf).
module fas_serial_alu #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fas_serial_alu_if.slave     ifc
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [N-1:0]   res_sh_q, res_sh_d;
    logic [N-1:0]   result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_q, op_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cell_sum_s;
    logic           cell_co_s;
    logic           accept_s;
`ifdef FAS_SERIAL_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    // One-bit full adder cell: returns {carry_out, sum}
    function automatic logic [1:0] fas_cell(input logic x, input logic y, input logic cin);
        logic s;
        logic c;
        s = x ^ y ^ cin;
        c = (x & y) | (cin & (x ^ y));
        return {c, s};
    endfunction

    // Next-state, datapath shifting and registered-output next values
    always_comb begin
        // Subtract feeds ~b with carry-in 1, i.e. a + ~b + 1
        {cell_co_s, cell_sum_s} = fas_cell(a_sh_q[0], b_sh_q[0] ^ ~op_q, carry_q);
        accept_s = ifc.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef FAS_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d  = ST_RUN;
                    a_sh_d   = ifc.a;
                    b_sh_d   = ifc.b;
                    op_d     = ifc.a_ns;
                    carry_d  = ~ifc.a_ns;
                    cnt_d    = {CW{1'b0}};
                    res_sh_d = {N{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[N-1:1]};
                b_sh_d   = {1'b0, b_sh_q[N-1:1]};
                res_sh_d = {cell_sum_s, res_sh_q[N-1:1]};
                carry_d  = cell_co_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    result_d = {cell_sum_s, res_sh_q[N-1:1]};
                    cout_d   = cell_co_s;
`ifdef FAS_SERIAL_OVF_EN
                    // carry_q here is the carry into the MSB position
                    ovf_d    = carry_q ^ cell_co_s;
`endif
                end else begin
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {N{1'b0}};
            b_sh_q   <= {N{1'b0}};
            res_sh_q <= {N{1'b0}};
            result_q <= {N{1'b0}};
            cnt_q    <= {CW{1'b0}};
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FAS_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef FAS_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ifc.busy   = busy_q;
    assign ifc.done   = done_q;
    assign ifc.result = result_q;
    assign ifc.cout   = cout_q;
`ifdef FAS_SERIAL_OVF_EN
    assign ifc.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_fas_serial_alu.sv
// Self-checking bench for fas_serial_alu (N=8): directed vector table,
// back-to-back and reset-abort sequences, and randomized operations checked
// against an arithmetic reference model.
module tb_fas_serial_alu;
    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fas_serial_alu_if #(.N(N)) ifc ();

    fas_serial_alu #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    logic [7:0] last_res  = 8'd0;
    logic       last_cout = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        bit         noise;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {ovf, cout, result}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic op);
        int ua, ub, sa, sb, ur, sr;
        logic [9:0] r;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        ur = op ? (ua + ub) : (ua - ub);
        sr = op ? (sa + sb) : (sa - sb);
        r[7:0] = ur[7:0];
        r[8]   = op ? (ur > 255) : (ua >= ub);
        r[9]   = (sr > 127) || (sr < -128);
        return r;
    endfunction

    // One operation: optional pre-driven start, optional mid-run start noise,
    // optional chaining of the next operation from the DONE cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                         input logic [7:0] er, input logic ec, input logic eo,
                         input bit noise, input bit pre, input bit chain,
                         input logic [7:0] na, input logic [7:0] nb, input logic nop,
                         input string tag);
        int busy_n, done_n, done_at;
        bit held;
        logic [7:0] rd;
        logic cd;
        logic od;
        busy_n = 0; done_n = 0; done_at = 0; held = 1'b1;
        rd = 8'd0; cd = 1'b0; od = 1'b0;
        if (!pre) begin
            @(negedge clk);
            ifc.start = 1'b1; ifc.a = a; ifc.b = b; ifc.a_ns = op;
        end
        @(posedge clk);
        for (int i = 1; i <= N + 2; i++) begin
            @(negedge clk);
            if (ifc.busy) busy_n++;
            if (ifc.done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            if (i <= N && (ifc.result !== last_res || ifc.cout !== last_cout)) held = 1'b0;
            if (i == N + 1) begin
                rd = ifc.result;
                cd = ifc.cout;
`ifdef FAS_SERIAL_OVF_EN
                od = ifc.ovf;
`endif
            end
            if (chain && i == N + 1) begin
                ifc.start = 1'b1; ifc.a = na; ifc.b = nb; ifc.a_ns = nop;
                break;
            end
            ifc.start = (noise && i >= 2 && i <= N - 1) ? 1'b1 : 1'b0;
            ifc.a     = 8'($urandom);
            ifc.b     = 8'($urandom);
            ifc.a_ns  = 1'($urandom);
        end
        check({tag, " busy_cycles"}, busy_n, N);
        check({tag, " done_cycle"}, done_at, N + 1);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " held_in_run"}, {31'd0, held}, 32'd1);
        check($sformatf("%s result (ovf exp %0b)", tag, eo), {24'd0, rd}, {24'd0, er});
        check({tag, " cout"}, {31'd0, cd}, {31'd0, ec});
`ifdef FAS_SERIAL_OVF_EN
        check({tag, " ovf"}, {31'd0, od}, {31'd0, eo});
`endif
        last_res  = er;
        last_cout = ec;
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] ra, rb;
        logic rop;
        bit saw_done;

        ifc.start = 1'b0; ifc.a = 8'd0; ifc.b = 8'd0; ifc.a_ns = 1'b0;

        // Reset state, with start asserted during reset (reset wins)
        ifc.start = 1'b1;
        #1;
        check("rst busy", {31'd0, ifc.busy}, 32'd0);
        check("rst done", {31'd0, ifc.done}, 32'd0);
        check("rst result", {24'd0, ifc.result}, 32'd0);
        check("rst cout", {31'd0, ifc.cout}, 32'd0);
        @(negedge clk);
        check("rst start ignored", {31'd0, ifc.busy}, 32'd0);
        ifc.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{8'd5,   8'd3,   1'b1, 8'd8,    1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd200, 8'd100, 1'b1, 8'h2C,   1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'd5,   8'd3,   1'b0, 8'd2,    1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'd3,   8'd5,   1'b0, 8'hFE,   1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'd127, 8'd1,   1'b1, 8'h80,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h80,  8'd1,   1'b0, 8'h7F,   1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'd0,   8'd0,   1'b0, 8'd0,    1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hFF,  8'd1,   1'b1, 8'd0,    1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'hFF,  8'hFF,  1'b0, 8'd0,    1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].cout, vecs[i].ovf,
                  vecs[i].noise, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, $sformatf("vec%0d", i));
        end

        // Back-to-back: start held in DONE, second op begins with no IDLE cycle
        do_op(8'd10, 8'd20, 1'b1, 8'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              8'd50, 8'd60, 1'b0, "b2b_first");
        do_op(8'd50, 8'd60, 1'b0, 8'hF6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              8'd0, 8'd0, 1'b0, "b2b_second");

        // Reset during RUN at bit 4: abort, outputs cleared, no done pulse
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'd100; ifc.b = 8'd27; ifc.a_ns = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, ifc.busy}, 32'd0);
        check("abort result", {24'd0, ifc.result}, 32'd0);
        check("abort cout", {31'd0, ifc.cout}, 32'd0);
        check("abort done", {31'd0, ifc.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (ifc.done || ifc.busy) saw_done = 1'b1;
        end
        check("abort quiet", {31'd0, saw_done}, 32'd0);
        last_res  = 8'd0;
        last_cout = 1'b0;
        do_op(8'd100, 8'd27, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              8'd0, 8'd0, 1'b0, "after_abort");

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 30; k++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 1'($urandom);
            m   = model(ra, rb, rop);
            do_op(ra, rb, rop, m[7:0], m[8], m[9], bit'($urandom_range(0, 1)), 1'b0, 1'b0,
                  8'd0, 8'd0, 1'b0, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
